vga_timing_ctrl: RTL

// - Sequences the 640x480@60 VGA raster from the 25 MHz pixel-enable strobe (pclk, 1-of-4 on 100 MHz clk).
// - Generates h_sync/v_sync/DE, pixel coordinates and frame/line pulses for the game renderer and I2C-fed sprite logic.
// - Sits between the pixel-strobe generator and the RGB datapath. Everything runs on clk; pclk is an enable, never a clock.
//

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 28 ++
 rtl/vga_timing_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster sequencer.
package vga_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  // Sync pins idle at the opposite of their asserted polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; wrap flags the increment that rolls over.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  localparam int W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: counters advance on the pixel strobe and the outputs
// decode the post-increment position in the same edge, so they track the counters exactly.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  input  logic       run,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [H_W-1:0] H_VIS_C  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_VIS_C  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_VISIBLE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  state_t         state, state_nxt;
  logic [H_W-1:0] h_cnt, h_dec;
  logic [V_W-1:0] v_cnt, v_dec;
  logic           h_inc, h_wrap, v_wrap, cnt_clr;
  logic           live;
  logic           de_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;

  assign h_inc   = pclk && (state == RUN);
  assign cnt_clr = (state == IDLE);

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_inc),
    .clr   (cnt_clr),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_wrap),
    .clr   (cnt_clr),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (pclk) begin
      state <= state_nxt;
    end
  end

  // Next-state and decode of the position the counters move to on this strobe.
  // Leaving RUN happens only on the strobe that would wrap the whole frame.
  always_comb begin
    state_nxt = state;
    live      = 1'b0;
    h_dec     = h_wrap ? '0 : h_cnt + H_W'(1);
    v_dec     = v_wrap ? '0 : (h_wrap ? v_cnt + V_W'(1) : v_cnt);
    case (state)
      IDLE: begin
        if (pclk && run) begin
          state_nxt = RUN;
          live      = 1'b1;
          h_dec     = '0;
          v_dec     = '0;
        end
      end
      RUN: begin
        if (h_wrap && v_wrap && !run) begin
          state_nxt = IDLE;
        end else begin
          live = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    de_nxt = live && (h_dec < H_VIS_C) && (v_dec < V_VIS_C);
    hs_nxt = sync_level(live && (h_dec >= HS_START) && (h_dec <= HS_END), SYNC_POL);
    vs_nxt = sync_level(live && (v_dec >= VS_START) && (v_dec <= VS_END), SYNC_POL);
    ls_nxt = live && (h_dec == '0);
    fs_nxt = ls_nxt && (v_dec == '0);
  end

  // Output register stage: levels load on strobes, pulses self-clear in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DE          <= 1'b0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      x_pixel     <= '0;
      y_pixel     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pclk) begin
      DE          <= de_nxt;
      h_sync      <= hs_nxt;
      v_sync      <= vs_nxt;
      x_pixel     <= de_nxt ? 10'(h_dec) : '0;
      y_pixel     <= de_nxt ? 10'(v_dec) : '0;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
